// File: rtl/usb_utmi_pkg.sv
// UTMI encodings, link-controller states and full-speed timing defaults
// shared by the UTM link controller slice.
package usb_utmi_pkg;

    typedef enum logic [1:0] {
        UTMI_LS_SE0 = 2'b00,
        UTMI_LS_J   = 2'b01,
        UTMI_LS_K   = 2'b10,
        UTMI_LS_SE1 = 2'b11
    } utmi_line_state_t;

    typedef enum logic [1:0] {
        UTMI_OP_NORMAL        = 2'b00,
        UTMI_OP_NON_DRIVING   = 2'b01,
        UTMI_OP_NO_STUFF_NRZI = 2'b10
    } utmi_op_mode_t;

    typedef enum logic [2:0] {
        DETACHED_S,
        ACTIVE_S,
        BUS_RESET_S,
        SUSPEND_S,
        RESUME_S
    } link_state_t;

    // Cycle counts at the 48 MHz UTM clock.
    localparam int unsigned USB_FS_ATTACH_CYC  = 8;
    localparam int unsigned USB_FS_RESET_CYC   = 120;
    localparam int unsigned USB_FS_SUSPEND_CYC = 144000;
    localparam int unsigned USB_FS_RESUME_CYC  = 48;
    localparam int unsigned USB_FS_TA_CYC      = 8;

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_utm_link_ctrl_if.sv
// UTM-side and SIE transmit-handshake signals of the link controller.
interface usb_utm_link_ctrl_if;
    import usb_utmi_pkg::*;

    utmi_line_state_t line_state;
    logic             rx_active;
    logic             tx_active;
    logic             tx_req;
    logic             tx_gnt;
    utmi_op_mode_t    op_mode;
    logic             suspend_m;

    modport master (
        input  line_state, rx_active, tx_active, tx_req,
        output tx_gnt, op_mode, suspend_m
    );

    modport slave (
        output line_state, rx_active, tx_active, tx_req,
        input  tx_gnt, op_mode, suspend_m
    );

endinterface

// File: rtl/usb_utm_link_ctrl_line_event_cnt.sv
// Saturating run-length counter: counts consecutive cycles of match,
// zeroes whenever match is low or clear is high; hit flags the limit.
module usb_line_event_cnt #(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic match,
    input  logic clear,
    output logic hit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !match) begin
            cnt_d = '0;
        end else if (cnt_q != LIM) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == LIM);

endmodule

// File: rtl/usb_utm_link_ctrl.sv
// FS UTM link controller: tracks attach/reset/suspend/resume from line_state,
// drives op_mode/suspend_m and arbitrates the half-duplex bus for the SIE.
module usb_utm_link_ctrl
    import usb_utmi_pkg::*;
#(
    parameter int unsigned ATTACH_CYC  = USB_FS_ATTACH_CYC,
    parameter int unsigned RESET_CYC   = USB_FS_RESET_CYC,
    parameter int unsigned SUSPEND_CYC = USB_FS_SUSPEND_CYC,
    parameter int unsigned RESUME_CYC  = USB_FS_RESUME_CYC,
    parameter int unsigned TA_CYC      = USB_FS_TA_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    usb_utm_link_ctrl_if.master  utm,
    output logic                 bus_reset,
    output logic                 suspended,
    output logic                 resume_pulse
);

    localparam int unsigned CNT_W = $clog2(max_u(max_u(ATTACH_CYC, RESET_CYC),
                                                 max_u(SUSPEND_CYC, RESUME_CYC)) + 1);
    localparam int unsigned TA_W  = $clog2(TA_CYC + 1);
    localparam logic [TA_W-1:0] TA_LIM = TA_W'(TA_CYC);

    link_state_t     state_q, state_d;
    logic [TA_W-1:0] ta_cnt_q, ta_cnt_d;
    logic            tx_gnt_q, tx_gnt_d;
    utmi_op_mode_t   op_mode_q, op_mode_d;
    logic            suspend_m_q, suspend_m_d;
    logic            bus_reset_q, bus_reset_d;
    logic            suspended_q, suspended_d;
    logic            resume_pulse_q, resume_pulse_d;
    logic            prev_se0_q, prev_se0_d;

    logic is_se0, is_j, is_k;
    logic se0_hit, j_hit, k_hit, idle_hit;

    assign is_se0 = (utm.line_state == UTMI_LS_SE0);
    assign is_j   = (utm.line_state == UTMI_LS_J);
    assign is_k   = (utm.line_state == UTMI_LS_K);

    usb_line_event_cnt #(.LIMIT(RESET_CYC), .W(CNT_W)) u_se0_cnt (
        .clk(clk), .rst_n(rst_n), .match(is_se0), .clear(1'b0), .hit(se0_hit));
    usb_line_event_cnt #(.LIMIT(ATTACH_CYC), .W(CNT_W)) u_j_cnt (
        .clk(clk), .rst_n(rst_n), .match(is_j), .clear(1'b0), .hit(j_hit));
    usb_line_event_cnt #(.LIMIT(RESUME_CYC), .W(CNT_W)) u_k_cnt (
        .clk(clk), .rst_n(rst_n), .match(is_k), .clear(1'b0), .hit(k_hit));
    usb_line_event_cnt #(.LIMIT(SUSPEND_CYC), .W(CNT_W)) u_idle_cnt (
        .clk(clk), .rst_n(rst_n), .match(is_j),
        .clear(utm.rx_active || utm.tx_active), .hit(idle_hit));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DETACHED_S:  if (j_hit) state_d = ACTIVE_S;
            ACTIVE_S: begin
                if (se0_hit)       state_d = BUS_RESET_S;
                else if (idle_hit) state_d = SUSPEND_S;
            end
            BUS_RESET_S: if (!is_se0) state_d = ACTIVE_S;
            SUSPEND_S: begin
                if (se0_hit)    state_d = BUS_RESET_S;
                else if (k_hit) state_d = RESUME_S;
            end
            RESUME_S: begin
                if (prev_se0_q && is_j) state_d = ACTIVE_S;
                else if (se0_hit)       state_d = BUS_RESET_S;
            end
            default: state_d = DETACHED_S;
        endcase

        // Turnaround is preset outside ACTIVE_S so the first request after entry
        // is not delayed; the grant tests the updated count so it can rise on
        // the TA_CYC-th edge after rx_active is first seen low.
        if (state_q != ACTIVE_S)      ta_cnt_d = TA_LIM;
        else if (utm.rx_active)       ta_cnt_d = '0;
        else if (ta_cnt_q != TA_LIM)  ta_cnt_d = ta_cnt_q + 1'b1;
        else                          ta_cnt_d = ta_cnt_q;

        tx_gnt_d = 1'b0;
        if (state_q == ACTIVE_S && state_d == ACTIVE_S) begin
            tx_gnt_d = tx_gnt_q ? utm.tx_req
                                : (utm.tx_req && !utm.rx_active && ta_cnt_d == TA_LIM);
        end

        op_mode_d      = (state_d == ACTIVE_S) ? UTMI_OP_NORMAL : UTMI_OP_NON_DRIVING;
        suspend_m_d    = (state_d != SUSPEND_S);
        bus_reset_d    = (state_d == BUS_RESET_S);
        suspended_d    = (state_d == SUSPEND_S);
        resume_pulse_d = (state_q == SUSPEND_S) && (state_d == RESUME_S);
        prev_se0_d     = is_se0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= DETACHED_S;
            ta_cnt_q       <= '0;
            tx_gnt_q       <= 1'b0;
            op_mode_q      <= UTMI_OP_NON_DRIVING;
            suspend_m_q    <= 1'b1;
            bus_reset_q    <= 1'b0;
            suspended_q    <= 1'b0;
            resume_pulse_q <= 1'b0;
            prev_se0_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ta_cnt_q       <= ta_cnt_d;
            tx_gnt_q       <= tx_gnt_d;
            op_mode_q      <= op_mode_d;
            suspend_m_q    <= suspend_m_d;
            bus_reset_q    <= bus_reset_d;
            suspended_q    <= suspended_d;
            resume_pulse_q <= resume_pulse_d;
            prev_se0_q     <= prev_se0_d;
        end
    end

    assign utm.tx_gnt    = tx_gnt_q;
    assign utm.op_mode   = op_mode_q;
    assign utm.suspend_m = suspend_m_q;
    assign bus_reset     = bus_reset_q;
    assign suspended     = suspended_q;
    assign resume_pulse  = resume_pulse_q;

endmodule

// File: tb/tb_usb_utm_link_ctrl.sv
// Bench for usb_utm_link_ctrl: directed vector table, async-reset sequence and
// random traffic, all checked against a history-based reference model.
module tb_usb_utm_link_ctrl;
    import usb_utmi_pkg::*;

    localparam int unsigned ATT   = 8;
    localparam int unsigned RST_C = 120;
    localparam int unsigned SUSP  = 300;
    localparam int unsigned RES   = 48;
    localparam int unsigned TA    = 8;

    // {tx_gnt, op_mode[1:0], suspend_m, bus_reset, suspended, resume_pulse}
    localparam logic [6:0] V_DET     = 7'b0011000;
    localparam logic [6:0] V_ACT     = 7'b0001000;
    localparam logic [6:0] V_ACT_GNT = 7'b1001000;
    localparam logic [6:0] V_RST     = 7'b0011100;
    localparam logic [6:0] V_SUSP    = 7'b0010010;
    localparam logic [6:0] V_RES_P   = 7'b0011001;
    localparam logic [6:0] V_RES     = 7'b0011000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic bus_reset, suspended, resume_pulse;
    int   tests = 0;
    int   fails = 0;

    usb_utm_link_ctrl_if utm();

    usb_utm_link_ctrl #(
        .ATTACH_CYC(ATT), .RESET_CYC(RST_C), .SUSPEND_CYC(SUSP),
        .RESUME_CYC(RES), .TA_CYC(TA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .utm(utm),
        .bus_reset(bus_reset), .suspended(suspended), .resume_pulse(resume_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: decisions come from the recorded line history
    // (run lengths) and edge timestamps rather than from counters.
    typedef enum int {M_DET, M_ACT, M_RST, M_SUSP, M_RES} mst_e;
    mst_e             m_st;
    logic             m_gnt, m_pulse;
    utmi_line_state_t h_ls[$];
    bit               h_idle[$];
    int               edge_no, last_rx_hi, act_entry;

    task automatic model_reset();
        m_st = M_DET; m_gnt = 1'b0; m_pulse = 1'b0;
        h_ls.delete(); h_idle.delete();
        edge_no = 0; last_rx_hi = -1000; act_entry = 0;
    endtask

    function automatic int unsigned run_ls(utmi_line_state_t v, int unsigned lim);
        int unsigned n = 0;
        for (int i = h_ls.size() - 1; i >= 0; i--) begin
            if (n == lim || h_ls[i] != v) break;
            n++;
        end
        return n;
    endfunction

    function automatic int unsigned run_idle(int unsigned lim);
        int unsigned n = 0;
        for (int i = h_idle.size() - 1; i >= 0; i--) begin
            if (n == lim || !h_idle[i]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_step();
        utmi_line_state_t cur = utm.line_state;
        bit   se0_hit, j_hit, k_hit, idle_hit, tx_ok, prev_se0;
        mst_e nxt;
        edge_no++;
        se0_hit  = (run_ls(UTMI_LS_SE0, RST_C) == RST_C);
        j_hit    = (run_ls(UTMI_LS_J, ATT) == ATT);
        k_hit    = (run_ls(UTMI_LS_K, RES) == RES);
        idle_hit = (run_idle(SUSP) == SUSP);
        prev_se0 = (h_ls.size() > 0) && (h_ls[h_ls.size() - 1] == UTMI_LS_SE0);
        nxt = m_st;
        case (m_st)
            M_DET:  if (j_hit) nxt = M_ACT;
            M_ACT:  if (se0_hit) nxt = M_RST; else if (idle_hit) nxt = M_SUSP;
            M_RST:  if (cur != UTMI_LS_SE0) nxt = M_ACT;
            M_SUSP: if (se0_hit) nxt = M_RST; else if (k_hit) nxt = M_RES;
            M_RES:  if (prev_se0 && cur == UTMI_LS_J) nxt = M_ACT;
                    else if (se0_hit) nxt = M_RST;
            default: nxt = M_DET;
        endcase
        if (utm.rx_active) last_rx_hi = edge_no;
        tx_ok = !utm.rx_active && (last_rx_hi <= act_entry || edge_no - last_rx_hi >= int'(TA));
        m_gnt = (m_st == M_ACT && nxt == M_ACT) && (m_gnt ? utm.tx_req : (utm.tx_req && tx_ok));
        m_pulse = (m_st == M_SUSP && nxt == M_RES);
        if (nxt == M_ACT && m_st != M_ACT) act_entry = edge_no;
        h_ls.push_back(cur);
        h_idle.push_back(cur == UTMI_LS_J && !utm.rx_active && !utm.tx_active);
        if (h_ls.size() > 400) begin
            void'(h_ls.pop_front());
            void'(h_idle.pop_front());
        end
        m_st = nxt;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    function automatic logic [6:0] exp_vec();
        return {m_gnt, (m_st == M_ACT) ? 2'b00 : 2'b01, m_st != M_SUSP,
                m_st == M_RST, m_st == M_SUSP, m_pulse};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {utm.tx_gnt, utm.op_mode, utm.suspend_m, bus_reset, suspended, resume_pulse};
    endfunction

    task automatic check(string name, logic [6:0] exp);
        tests++;
        if (dut_vec() !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, dut_vec(), exp);
        end
    endtask

    task automatic drive(utmi_line_state_t ls, logic rx, logic tx, logic req);
        utm.line_state = ls;
        utm.rx_active  = rx;
        utm.tx_active  = tx;
        utm.tx_req     = req;
    endtask

    typedef struct {
        utmi_line_state_t ls;
        logic             rx, tx, req;
        int               n;
        logic [6:0]       exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(utmi_line_state_t ls, logic rx, logic req, int n, logic [6:0] exp);
        vec_t v;
        v.ls = ls; v.rx = rx; v.tx = 1'b0; v.req = req; v.n = n; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        int cyc;
        logic rx, tx, req;
        utmi_line_state_t ls;

        drive(UTMI_LS_SE0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_values", V_DET);
        rst_n = 1'b1;

        add(UTMI_LS_J,   0, 0,   7, V_DET);      // 7 J: not attached
        add(UTMI_LS_K,   0, 0,   1, V_DET);
        add(UTMI_LS_J,   0, 0,   8, V_DET);      // count reaches 8
        add(UTMI_LS_J,   0, 0,   1, V_ACT);      // attached on cycle 9
        add(UTMI_LS_SE0, 0, 0, 119, V_ACT);      // one short of reset
        add(UTMI_LS_J,   0, 0,   1, V_ACT);
        add(UTMI_LS_SE0, 0, 0, 120, V_ACT);
        add(UTMI_LS_SE0, 0, 0,   1, V_RST);      // bus reset on cycle 121
        add(UTMI_LS_SE0, 0, 0,   5, V_RST);
        add(UTMI_LS_J,   0, 0,   1, V_ACT);      // reset ends
        add(UTMI_LS_K,   0, 0,   1, V_ACT);
        add(UTMI_LS_J,   0, 0, 300, V_ACT);      // idle reaches limit
        add(UTMI_LS_J,   0, 0,   1, V_SUSP);
        add(UTMI_LS_K,   0, 0,  48, V_SUSP);
        add(UTMI_LS_K,   0, 0,   1, V_RES_P);    // single-cycle resume pulse
        add(UTMI_LS_K,   0, 0,   1, V_RES);
        add(UTMI_LS_SE0, 0, 0,   2, V_RES);
        add(UTMI_LS_J,   0, 0,   1, V_ACT);      // resume EOP
        add(UTMI_LS_K,   1, 1, 100, V_ACT);      // rx holds off grant
        add(UTMI_LS_K,   0, 1,   7, V_ACT);
        add(UTMI_LS_K,   0, 1,   1, V_ACT_GNT);  // 8 cycles after rx falls
        add(UTMI_LS_K,   1, 1,   5, V_ACT_GNT);  // own echo ignored
        add(UTMI_LS_K,   0, 0,   1, V_ACT);      // req drop -> gnt drop
        add(UTMI_LS_K,   1, 1,  20, V_ACT);      // simultaneous rise: rx wins
        add(UTMI_LS_K,   0, 1,   7, V_ACT);
        add(UTMI_LS_K,   0, 1,   1, V_ACT_GNT);
        add(UTMI_LS_SE0, 0, 1, 120, V_ACT_GNT);
        add(UTMI_LS_SE0, 0, 1,   1, V_RST);      // gnt dropped on reset entry
        add(UTMI_LS_J,   0, 1,   1, V_ACT);
        add(UTMI_LS_K,   0, 1,   1, V_ACT_GNT);  // preset turnaround

        foreach (tbl[k]) begin
            drive(tbl[k].ls, tbl[k].rx, tbl[k].tx, tbl[k].req);
            for (int i = 0; i < tbl[k].n; i++) begin
                @(negedge clk);
                check($sformatf("model_vec%0d", k), exp_vec());
            end
            check($sformatf("vec%0d", k), tbl[k].exp);
        end

        // Asynchronous reset while granted, checked before the next clk edge.
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", V_DET);
        check("async_reset_model", exp_vec());
        tests++;
        if (dut.state_q !== DETACHED_S) begin
            fails++;
            $display("FAIL async_reset_state: got %0d expected %0d",
                     int'(dut.state_q), int'(DETACHED_S));
        end
        drive(UTMI_LS_SE0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc = 0; rx = 1'b0; tx = 1'b0; req = 1'b0;
        while (cyc < 4000) begin
            int unsigned pick, len;
            bit quiet;
            pick  = $urandom_range(0, 9);
            quiet = 1'b0;
            case (pick)
                0, 1, 2, 3: begin ls = utmi_line_state_t'($urandom_range(0, 3)); len = $urandom_range(1, 12); end
                4:          begin ls = UTMI_LS_SE0; len = $urandom_range(115, 125); end
                5:          begin ls = UTMI_LS_K;   len = $urandom_range(40, 55); end
                6:          begin ls = UTMI_LS_J;   len = $urandom_range(290, 310); quiet = 1'b1; end
                default:    begin ls = ($urandom_range(0, 1) == 0) ? UTMI_LS_J : UTMI_LS_K;
                                  len = $urandom_range(1, 20); end
            endcase
            for (int i = 0; i < int'(len); i++) begin
                if (quiet) begin
                    rx = 1'b0; tx = 1'b0;
                end else begin
                    if ($urandom_range(0, 5) == 0) rx = ~rx;
                    tx = ($urandom_range(0, 15) == 0);
                end
                if ($urandom_range(0, 5) == 0) req = ~req;
                drive(ls, rx, tx, req);
                @(negedge clk);
                check("random", exp_vec());
                cyc++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
